param_reg_file: RTL and testbench
=================================

PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter DEPTH, default 32, register count; power of two, >= 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width; derived, never overridden.
REQ-004 Parameter ZERO_REG, default 1; 1 = register 0 reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle write data forwarded to matching read port.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 we  input  1  write enable for the writeback port.
REQ-009 waddr  input  ADDR_W  writeback register address.
REQ-010 wdata  input  DATA_W  writeback data.
REQ-011 raddr1, raddr2  input  ADDR_W  read addresses.
REQ-012 rdata1, rdata2  output  DATA_W  read data, combinational.
REQ-013 issue  input  1  an instruction with a destination register is issued this cycle.
REQ-014 issue_rd  input  ADDR_W  destination register of the issued instruction.
REQ-015 busy1, busy2  output  1  pending write exists for raddr1/raddr2.
REQ-016 hazard  output  1  busy1 | busy2; stall request to the issue stage.

Function
REQ-017 Write SHALL occur at the rising edge of clk when we=1; no write when we=0.
REQ-018 Read SHALL be combinational from raddrN; no read latency.
REQ-019 When BYPASS=1, we=1 and waddr==raddrN (nonzero under ZERO_REG=1), rdataN SHALL equal wdata in the same cycle.
REQ-020 When BYPASS=0, rdataN SHALL show the stored value; the new value appears the cycle after the edge.
REQ-021 When ZERO_REG=1, reading address 0 SHALL give 0, writes to address 0 SHALL be dropped, and busy for address 0 SHALL never be set.
REQ-022 The module SHALL keep one busy bit per register (scoreboard).
REQ-023 At the clock edge, issue=1 SHALL set busy[issue_rd]; we=1 SHALL clear busy[waddr].
REQ-024 When set and clear hit the same register in the same cycle, set SHALL win (newer producer pending).
REQ-025 busyN SHALL equal busy[raddrN], except it SHALL be 0 when BYPASS=1, we=1 and waddr==raddrN; in that case the data is already forwarded.
REQ-026 hazard SHALL be combinational; the block SHALL NOT itself gate issue.
REQ-027 Addresses >= DEPTH cannot occur; no out-of-range handling is required.
REQ-028 A write to a register that is not busy SHALL still update the data and leave busy at 0.

Reset
REQ-029 While rst_n=0, all registers SHALL read 0, with these presets: reg 19 = 5, reg 20 = 20, reg 21 = 40 (only where index < DEPTH).
REQ-030 While rst_n=0, all busy bits SHALL be 0, so busy1, busy2 and hazard read 0.
REQ-031 Reset asserted mid-operation SHALL immediately discard pending writes and the scoreboard.
REQ-032 The first write SHALL take effect on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package regfile_pkg SHALL hold: default DATA_W/DEPTH constants, preset index/value table (19/5, 20/20, 21/40), and the ZERO_REG index constant.
REQ-034 The scoreboard SHALL be a sub-module named regfile_scoreboard (busy vector, set/clear priority, two lookup ports).
REQ-035 The storage array and bypass muxes SHALL stay in param_reg_file.

Verification
REQ-036 Reset release, then read 19/20/21/5 -> 5/20/40/0; busy1=busy2=hazard=0.
REQ-037 we=1, waddr=3, wdata=0xDEADBEEF, raddr1=3 in the same cycle -> BYPASS=1: rdata1=0xDEADBEEF that cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
REQ-038 Write 0x1234 to reg 0 with ZERO_REG=1 -> rdata=0; issue_rd=0 -> busy stays 0.
REQ-039 issue=1, rd=7; next cycle raddr2=7 -> busy2=1, hazard=1; writeback we=1, waddr=7 -> busy2=0 that cycle, cleared after the edge.
REQ-040 In the same cycle, issue=1 with rd=9, and we=1 with waddr=9 -> after the edge busy[9]=1 and reg 9 holds the written data.
REQ-041 DATA_W=16, DEPTH=8: write 0xFFFF to reg 7, then read -> 0xFFFF; presets absent, all regs reset to 0; rst_n pulsed low mid-run -> all data and busy bits 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the parameterised register file: default geometry,
// the hard-wired zero register index and the reset preset table.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 32;
  localparam int unsigned ZERO_REG_IDX = 0;

  // Registers that come out of reset with a non-zero value.
  localparam int unsigned N_PRESETS = 3;
  localparam logic [N_PRESETS-1:0][31:0] PRESET_IDX = {32'd21, 32'd20, 32'd19};
  localparam logic [N_PRESETS-1:0][31:0] PRESET_VAL = {32'd40, 32'd20, 32'd5};

  // Reset value for register idx; 0 when the index has no preset.
  function automatic logic [31:0] preset_value(input int unsigned idx);
    preset_value = '0;
    for (int unsigned k = 0; k < N_PRESETS; k++) begin
      if (PRESET_IDX[k] == idx) preset_value = PRESET_VAL[k];
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: issue sets a bit, writeback clears
// it, a same-cycle set beats a clear on the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] look_idx1,
  input  logic [ADDR_W-1:0] look_idx2,
  output logic              busy1,
  output logic              busy2
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clear first so that a set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  // Busy register, discarded asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookup ports.
  always_comb begin
    busy1 = busy_q[look_idx1];
    busy2 = busy_q[look_idx2];
  end

endmodule

// File: rtl/param_reg_file.sv
// Two-read / one-write register file with optional write-to-read bypass,
// optional hard-wired zero register and a pending-write scoreboard that
// raises a stall request (hazard) for the issue stage.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard
);

  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;
  logic              set_en;
  logic              zero1, zero2;
  logic              fwd1, fwd2;
  logic              sb_busy1, sb_busy2;

  // Write decode; the zero register swallows writes and never goes busy.
  always_comb begin
    wr_en  = we    && !(ZERO_REG != 0 && waddr    == ZIDX);
    set_en = issue && !(ZERO_REG != 0 && issue_rd == ZIDX);
    mem_d  = mem_q;
    if (wr_en) mem_d[waddr] = wdata;
  end

  // Storage array with preset reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(preset_value(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read muxes. Forwarding is held off during reset so reads show the
  // reset contents rather than whatever sits on wdata.
  always_comb begin
    zero1  = (ZERO_REG != 0) && (raddr1 == ZIDX);
    zero2  = (ZERO_REG != 0) && (raddr2 == ZIDX);
    fwd1   = (BYPASS != 0) && rst_n && we && (waddr == raddr1) && !zero1;
    fwd2   = (BYPASS != 0) && rst_n && we && (waddr == raddr2) && !zero2;
    rdata1 = zero1 ? '0 : (fwd1 ? wdata : mem_q[raddr1]);
    rdata2 = zero2 ? '0 : (fwd2 ? wdata : mem_q[raddr2]);
    busy1  = sb_busy1 && !fwd1;
    busy2  = sb_busy2 && !fwd2;
    hazard = busy1 || busy2;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_idx   (issue_rd),
    .clr_en    (we),
    .clr_idx   (waddr),
    .look_idx1 (raddr1),
    .look_idx2 (raddr2),
    .busy1     (sb_busy1),
    .busy2     (sb_busy2)
  );

endmodule

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32 instances (bypass on / bypass off).
  logic        rst_n;
  logic        we, issue;
  logic [4:0]  waddr, raddr1, raddr2, issue_rd;
  logic [31:0] wdata;
  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic        a_busy1, a_busy2, a_hazard, b_busy1, b_busy2, b_hazard;

  // Small instance: DATA_W=16, DEPTH=8.
  logic        c_rst_n, c_we, c_issue;
  logic [2:0]  c_waddr, c_raddr1, c_raddr2, c_rd;
  logic [15:0] c_wdata, c_rdata1, c_rdata2;
  logic        c_busy1, c_busy2, c_hazard;

  param_reg_file #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rdata1), .rdata2(a_rdata2),
    .issue(issue), .issue_rd(issue_rd), .busy1(a_busy1), .busy2(a_busy2), .hazard(a_hazard));

  param_reg_file #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
    .issue(issue), .issue_rd(issue_rd), .busy1(b_busy1), .busy2(b_busy2), .hazard(b_hazard));

  param_reg_file #(.DATA_W(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .raddr1(c_raddr1), .raddr2(c_raddr2), .rdata1(c_rdata1), .rdata2(c_rdata2),
    .issue(c_issue), .issue_rd(c_rd), .busy1(c_busy1), .busy2(c_busy2), .hazard(c_hazard));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: register contents and pending-write set.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = (i == 19) ? 32'd5 : (i == 20) ? 32'd20 : (i == 21) ? 32'd40 : 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_edge();
    if (we && waddr != 0) m_mem[waddr] = wdata;
    if (we) m_busy[waddr] = 1'b0;
    if (issue && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] addr, input bit byp);
    if (addr == 0) return 32'd0;
    if (byp && we && waddr == addr) return wdata;
    return m_mem[addr];
  endfunction

  function automatic logic m_bz(input logic [4:0] addr, input bit byp);
    if (byp && we && waddr == addr && addr != 0) return 1'b0;
    return m_busy[addr];
  endfunction

  task automatic check_model();
    chk("a_rdata1", a_rdata1, m_rd(raddr1, 1'b1));
    chk("a_rdata2", a_rdata2, m_rd(raddr2, 1'b1));
    chk("a_busy1", 32'(a_busy1), 32'(m_bz(raddr1, 1'b1)));
    chk("a_busy2", 32'(a_busy2), 32'(m_bz(raddr2, 1'b1)));
    chk("a_hazard", 32'(a_hazard), 32'(m_bz(raddr1, 1'b1) | m_bz(raddr2, 1'b1)));
    chk("b_rdata1", b_rdata1, m_rd(raddr1, 1'b0));
    chk("b_rdata2", b_rdata2, m_rd(raddr2, 1'b0));
    chk("b_busy1", 32'(b_busy1), 32'(m_bz(raddr1, 1'b0)));
    chk("b_busy2", 32'(b_busy2), 32'(m_bz(raddr2, 1'b0)));
    chk("b_hazard", 32'(b_hazard), 32'(m_bz(raddr1, 1'b0) | m_bz(raddr2, 1'b0)));
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0; issue = 0; issue_rd = 0;
  endtask

  // Directed vectors for the bypass instance, one per clock cycle.
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1, ra2;
    logic        iss;
    logic [4:0]  rd;
    logic [31:0] e1, e2;
    logic        eb1, eb2, ehz;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        5'd19, 5'd20, 1'b0, 5'd0, 32'd5,        32'd20,      1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd21, 5'd5,  1'b0, 5'd0, 32'd40,       32'd0,       1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3,  5'd0,  1'b0, 5'd0, 32'hDEADBEEF, 32'd0,       1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd0,  1'b0, 5'd0, 32'hDEADBEEF, 32'd0,       1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'd0, 32'h1234,     5'd0,  5'd0,  1'b1, 5'd0, 32'd0,        32'd0,       1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0, 32'd0,        32'd0,       1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  1'b1, 5'd7, 32'd0,        32'd0,       1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  1'b0, 5'd0, 32'd0,        32'd0,       1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 5'd7, 32'hA5A5,     5'd0,  5'd7,  1'b0, 5'd0, 32'd0,        32'hA5A5,    1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  1'b0, 5'd0, 32'd0,        32'hA5A5,    1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd9, 32'h99,       5'd9,  5'd0,  1'b1, 5'd9, 32'h99,       32'd0,       1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd0,  1'b0, 5'd0, 32'h99,       32'd0,       1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 5'd9, 32'h100,      5'd9,  5'd9,  1'b0, 5'd0, 32'h100,      32'h100,     1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd0,  1'b0, 5'd0, 32'h100,      32'd0,       1'b0, 1'b0, 1'b0};
  end

  initial begin
    rst_n = 1'b0; c_rst_n = 1'b0;
    idle_inputs();
    c_we = 0; c_issue = 0; c_waddr = 0; c_wdata = 0; c_raddr1 = 0; c_raddr2 = 0; c_rd = 0;
    m_reset();

    // Contents while reset is held.
    @(posedge clk); #1;
    raddr1 = 19; raddr2 = 21; #1;
    chk("rst_hold_rd1", a_rdata1, 32'd5);
    chk("rst_hold_rd2", a_rdata2, 32'd40);
    chk("rst_hold_hazard", 32'(a_hazard), 32'd0);

    @(negedge clk); rst_n = 1'b1; c_rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      raddr1 = tbl[i].ra1; raddr2 = tbl[i].ra2; issue = tbl[i].iss; issue_rd = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd1", i), a_rdata1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), a_rdata2, tbl[i].e2);
      chk($sformatf("tbl%0d_busy1", i), 32'(a_busy1), 32'(tbl[i].eb1));
      chk($sformatf("tbl%0d_busy2", i), 32'(a_busy2), 32'(tbl[i].eb2));
      chk($sformatf("tbl%0d_hazard", i), 32'(a_hazard), 32'(tbl[i].ehz));
      check_model();
      m_edge();
      @(posedge clk); #1;
    end

    // No-bypass instance: old value in the write cycle, new value after.
    idle_inputs();
    we = 1; waddr = 3; wdata = 32'hCAFEF00D; raddr1 = 3;
    @(negedge clk);
    chk("nobyp_same_cycle", b_rdata1, 32'hDEADBEEF);
    chk("byp_same_cycle", a_rdata1, 32'hCAFEF00D);
    m_edge();
    @(posedge clk); #1;
    we = 0;
    @(negedge clk);
    chk("nobyp_next_cycle", b_rdata1, 32'hCAFEF00D);
    @(posedge clk); #1;

    // Randomised traffic, addresses biased toward a small window for hits.
    for (int n = 0; n < 400; n++) begin
      we       = 1'($urandom_range(0, 1));
      waddr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wdata    = $urandom;
      raddr1   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      raddr2   = 5'($urandom_range(0, 7));
      issue    = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      @(negedge clk);
      check_model();
      m_edge();
      @(posedge clk); #1;
    end

    // Mid-run reset throws away data and scoreboard immediately.
    idle_inputs();
    issue = 1; issue_rd = 11; we = 1; waddr = 12; wdata = 32'h77;
    @(negedge clk); m_edge();
    @(posedge clk); #1;
    idle_inputs();
    raddr1 = 12; raddr2 = 11;
    @(negedge clk);
    check_model();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd1", a_rdata1, 32'd0);
    chk("midrst_busy2", 32'(a_busy2), 32'd0);
    chk("midrst_hazard", 32'(a_hazard), 32'd0);
    raddr1 = 20; #1;
    chk("midrst_preset", a_rdata1, 32'd20);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    raddr1 = 11; raddr2 = 19;
    @(negedge clk);
    check_model();
    @(posedge clk); #1;

    // Narrow instance: no presets, full-width write, mid-run reset.
    for (int i = 0; i < 8; i++) begin
      c_raddr1 = 3'(i); #1;
      chk($sformatf("c_reset_reg%0d", i), 32'(c_rdata1), 32'd0);
    end
    @(posedge clk); #1;
    c_we = 1; c_waddr = 7; c_wdata = 16'hFFFF; c_issue = 1; c_rd = 3;
    @(posedge clk); #1;
    c_we = 0; c_issue = 0; c_raddr1 = 7; c_raddr2 = 3; #1;
    chk("c_rd_ffff", 32'(c_rdata1), 32'h0000FFFF);
    chk("c_busy2", 32'(c_busy2), 32'd1);
    chk("c_hazard", 32'(c_hazard), 32'd1);
    c_rst_n = 1'b0; #1;
    chk("c_midrst_rd", 32'(c_rdata1), 32'd0);
    chk("c_midrst_busy2", 32'(c_busy2), 32'd0);
    chk("c_midrst_hazard", 32'(c_hazard), 32'd0);
    @(negedge clk); c_rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
